// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for a multi-digit seven-segment
// display. It feeds one digit code per slot to a shared BCD decoder, drives
// the active-low anode, the decimal point and PWM brightness gating. New
// display data is taken through a load handshake and becomes visible only at
// a frame boundary, so a frame never mixes old and new digits.
//
// Handshake: load/ready follow valid/ready rules. A transfer happens in any
// cycle where load && ready is high at the rising clock edge. While ready is
// low, load is ignored, and the data already pending wins. ready stays low
// from the cycle after an accept until the cycle after the frame boundary
// that copies the pending data into the display shadow.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int PRESC  = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [2:0]            bright,
  input  logic                  load,
  output logic                  ready,
  output logic [3:0]            dig_code,
  output logic [DIGITS-1:0]     an,
  output logic                  dp_out,
  output logic                  frame
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESC - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  // Scan counters
  logic [PW-1:0] pcnt, pcnt_n;
  logic [2:0]    tcnt, tcnt_n;
  logic [IW-1:0] idx, idx_n;

  // Pending (written by load) and shadow (displayed) copies
  logic [4*DIGITS-1:0] pend_value, sh_value, sh_value_n;
  logic [DIGITS-1:0]   pend_dp, sh_dp, sh_dp_n;
  logic                pend_blz, sh_blz, sh_blz_n;
  logic                pend_valid;

  // Per-cycle events
  logic tick, slot_end, boundary, commit, accept;

  // Output next values
  logic                lit;
  logic [DIGITS-1:0]   blank;
  logic                zeros;
  logic [4*DIGITS-1:0] shifted;
  logic [3:0]          code_n;
  logic [DIGITS-1:0]   an_n;
  logic                dp_n;

  // Ready simply mirrors the absence of pending data.
  assign ready = ~pend_valid;

  // Counter advance, frame boundary detection and shadow next values
  always_comb begin
    tick     = (pcnt == PCNT_MAX);
    slot_end = tick && (tcnt == 3'd7);
    boundary = slot_end && (idx == IDX_MAX);
    commit   = boundary && pend_valid;
    accept   = load && ready;
    pcnt_n   = tick ? '0 : pcnt + 1'b1;
    tcnt_n   = tick ? tcnt + 3'd1 : tcnt;
    idx_n    = idx;
    if (slot_end) begin
      idx_n = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
    sh_value_n = commit ? pend_value : sh_value;
    sh_dp_n    = commit ? pend_dp    : sh_dp;
    sh_blz_n   = commit ? pend_blz   : sh_blz;
  end

  // Leading-zero mask: digit i blanks when it and every higher digit are zero
  always_comb begin
    zeros = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zeros    = zeros && (sh_value_n[4*i +: 4] == 4'h0);
      blank[i] = sh_blz_n && zeros;
    end
  end

  // Output values for the slot the counters are about to enter, so the
  // registered outputs line up with the counters and the new shadow data
  always_comb begin
    lit     = (tcnt_n <= bright);
    shifted = sh_value_n >> {idx_n, 2'b00};
    code_n  = blank[idx_n] ? 4'hF : shifted[3:0];
    an_n    = '1;
    if (lit) begin
      an_n[idx_n] = 1'b0;
    end
    dp_n = sh_dp_n[idx_n] && lit;
  end

  // Counters, pending capture and shadow commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      tcnt       <= '0;
      idx        <= '0;
      pend_valid <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blz   <= 1'b0;
      sh_value   <= '1;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
    end else begin
      pcnt     <= pcnt_n;
      tcnt     <= tcnt_n;
      idx      <= idx_n;
      sh_value <= sh_value_n;
      sh_dp    <= sh_dp_n;
      sh_blz   <= sh_blz_n;
      // Commit and accept never collide: accept requires pend_valid == 0,
      // so an accept in a boundary cycle waits for the next boundary.
      if (commit) begin
        pend_valid <= 1'b0;
      end
      if (accept) begin
        pend_valid <= 1'b1;
        pend_value <= value;
        pend_dp    <= dp;
        pend_blz   <= blank_lz;
      end
    end
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_code <= 4'hF;
      an       <= '1;
      dp_out   <= 1'b0;
      frame    <= 1'b0;
    end else begin
      dig_code <= code_n;
      an       <= an_n;
      dp_out   <= dp_n;
      frame    <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with DIGITS=4, PRESC=2, so a slot
// is 16 cycles and a frame is 64 cycles. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int PRESC  = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [2:0]          bright;
  logic                load;
  logic                ready;
  logic [3:0]          dig_code;
  logic [DIGITS-1:0]   an;
  logic                dp_out;
  logic                frame;

  seg_scan #(.DIGITS(DIGITS), .PRESC(PRESC)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dp       (dp),
    .blank_lz (blank_lz),
    .bright   (bright),
    .load     (load),
    .ready    (ready),
    .dig_code (dig_code),
    .an       (an),
    .dp_out   (dp_out),
    .frame    (frame)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until frame is seen; n is the number of edges taken.
  task automatic wait_frame(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      n++;
      if (frame) found = 1'b1;
    end
    if (!found) check("frame_timeout", 32'd0, 32'd1);
  endtask

  // Syncs to a frame, loads mid-frame and waits for the commit boundary.
  task automatic load_commit(input logic [15:0] v, input logic [3:0] d, input logic b);
    int n;
    wait_frame(n);
    value = v; dp = d; blank_lz = b; load = 1'b1;
    step();
    load = 1'b0;
    check("ready_low_after_accept", ready, 1'b0);
    wait_frame(n);
    check("commit_latency", n, 63);
    check("ready_after_commit", ready, 1'b1);
  endtask

  // Starting at the frame-pulse sample, checks one full frame. codes holds
  // the hand-computed code per digit (digit 0 in [3:0]).
  task automatic check_frame(input logic [15:0] codes, input logic [3:0] d, input int br);
    int sl, t;
    logic [3:0] ea;
    logic [3:0] ec;
    logic lit;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 16; c++) exp_q.push_back(codes[4*s +: 4]);
    for (int k = 0; k < 64; k++) begin
      sl  = k / 16;
      t   = (k % 16) / 2;
      lit = (t <= br);
      ea  = 4'hF;
      if (lit) ea[sl] = 1'b0;
      ec  = exp_q.pop_front();
      check("code", dig_code, ec);
      check("an", an, ea);
      check("dp", dp_out, d[sl] && lit);
      if (k < 2) check("frame", frame, k == 0);
      if (k < 63) step();
    end
  endtask

  // Stimulus
  initial begin
    int n;
    value = '0; dp = '0; blank_lz = 1'b0; bright = 3'd7; load = 1'b0;

    // Reset state
    step(); step();
    check("rst_an", an, 4'b1111);
    check("rst_code", dig_code, 4'hF);
    check("rst_ready", ready, 1'b1);
    check("rst_frame", frame, 1'b0);
    check("rst_dp", dp_out, 1'b0);
    rst = 1'b0;
    step();
    check("first_an", an, 4'b1110);
    check("first_code", dig_code, 4'hF);
    wait_frame(n);
    check("first_frame_gap", n, 63);
    wait_frame(n);
    check("frame_period", n, 64);

    // Basic scan
    load_commit(16'h1234, 4'b0100, 1'b0);
    check_frame(16'h1234, 4'b0100, 7);

    // Leading zeros
    load_commit(16'h0040, 4'b0000, 1'b1);
    check_frame(16'hFF40, 4'b0000, 7);
    load_commit(16'h0040, 4'b0000, 1'b0);
    check_frame(16'h0040, 4'b0000, 7);
    load_commit(16'h0000, 4'b0000, 1'b1);
    check_frame(16'hFFF0, 4'b0000, 7);

    // Handshake: accept mid-frame, ignored second load, accept on boundary
    wait_frame(n);
    repeat (20) step();
    value = 16'h2468; dp = 4'b0001; blank_lz = 1'b0; load = 1'b1;
    step();
    value = 16'h9999; dp = 4'b1111;
    check("hs_ready_low", ready, 1'b0);
    step();
    load = 1'b0;
    check("hs_ignored_ready", ready, 1'b0);
    repeat (41) step();
    check("hs_ready_before_bnd", ready, 1'b0);
    step();
    check("hs_frame", frame, 1'b1);
    check("hs_ready_after_bnd", ready, 1'b1);
    check_frame(16'h2468, 4'b0001, 7);
    value = 16'h1357; dp = 4'b0010; load = 1'b1;
    step();
    load = 1'b0;
    check("bnd_frame", frame, 1'b1);
    check("bnd_ready_low", ready, 1'b0);
    check("bnd_old_code", dig_code, 4'h8);
    wait_frame(n);
    check("bnd_commit_gap", n, 64);
    check("bnd_ready_high", ready, 1'b1);
    check_frame(16'h1357, 4'b0010, 7);

    // Brightness
    bright = 3'd2;
    wait_frame(n);
    check_frame(16'h1357, 4'b0010, 2);
    bright = 3'd7;
    wait_frame(n);
    repeat (5) step();
    check("br_lit", an, 4'b1110);
    bright = 3'd2;
    step();
    check("br_dark", an, 4'b1111);
    bright = 3'd3;
    step();
    check("br_relit", an, 4'b1110);
    bright = 3'd7;

    // Reset mid-operation with pending data at slot 2
    wait_frame(n);
    repeat (2) step();
    value = 16'h4321; dp = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    repeat (32) step();
    check("mid_pending", ready, 1'b0);
    check("mid_slot2", an, 4'b1011);
    rst = 1'b1;
    #1;
    check("mr_an", an, 4'b1111);
    check("mr_code", dig_code, 4'hF);
    check("mr_dp", dp_out, 1'b0);
    check("mr_frame", frame, 1'b0);
    check("mr_ready", ready, 1'b1);
    step(); step();
    check("mr_hold_an", an, 4'b1111);
    rst = 1'b0;
    wait_frame(n);
    check("mr_frame_gap", n, 64);
    check_frame(16'hFFFF, 4'b0000, 7);
    load_commit(16'h5678, 4'b1000, 1'b0);
    check_frame(16'h5678, 4'b1000, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
